// File: rtl/icache_sa_pkg.sv
// icache_sa_pkg: shared geometry defaults, FSM state encoding and a width
// helper for the set-associative instruction cache.
package icache_sa_pkg;

    localparam int ICS_LINE_BYTES = 64;
    localparam int ICS_SETS       = 16;
    localparam int ICS_WAYS       = 2;

    typedef enum logic {
        ICS_IDLE = 1'b0,
        ICS_MISS = 1'b1
    } ics_state_e;

    // Width of a field that selects one of n items; never narrower than one
    // bit so that degenerate geometries (one set, one way) still elaborate.
    function automatic int ics_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_sa_array.sv
// icache_sa_array: per-way tag / valid / line storage with a parallel tag
// compare on the lookup index.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears valid bits)
//   flush           clears every valid bit (caller gates it with rdy)
//   rd_index/rd_tag lookup set and tag
//   hit, hit_way    a valid way of rd_index holds rd_tag, and which one
//   rd_lines        line data of every way in set rd_index
//   wr_en/...       install wr_line with wr_tag into way wr_way of wr_index
//   wr_set_valid    valid bits of set wr_index, used for victim selection
module icache_sa_array
    import icache_sa_pkg::*;
#(
    parameter int LINE_BYTES = ICS_LINE_BYTES,
    parameter int SETS       = ICS_SETS,
    parameter int WAYS       = ICS_WAYS,
    parameter int IDX_W      = ics_bits(SETS),
    parameter int TAG_W      = 32 - $clog2(LINE_BYTES) - $clog2(SETS),
    parameter int PTR_W      = ics_bits(WAYS),
    parameter int LINE_W     = LINE_BYTES * 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [IDX_W-1:0]             rd_index,
    input  logic [TAG_W-1:0]             rd_tag,
    output logic                         hit,
    output logic [PTR_W-1:0]             hit_way,
    output logic [WAYS-1:0][LINE_W-1:0]  rd_lines,
    input  logic                         wr_en,
    input  logic [PTR_W-1:0]             wr_way,
    input  logic [IDX_W-1:0]             wr_index,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic [LINE_W-1:0]            wr_line,
    output logic [WAYS-1:0]              wr_set_valid
);

    logic [WAYS-1:0][SETS-1:0] valid;
    logic [TAG_W-1:0]          tag_mem  [WAYS][SETS];
    logic [LINE_W-1:0]         data_mem [WAYS][SETS];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_way][wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_way][wr_index]  <= wr_tag;
            data_mem[wr_way][wr_index] <= wr_line;
        end
    end

    // Installs only ever target a miss, so at most one way can match.
    always_comb begin
        hit          = 1'b0;
        hit_way      = '0;
        rd_lines     = '0;
        wr_set_valid = '0;
        for (int w = 0; w < WAYS; w++) begin
            rd_lines[w]     = data_mem[w][rd_index];
            wr_set_valid[w] = valid[w][wr_index];
            if (valid[w][rd_index] && (tag_mem[w][rd_index] == rd_tag)) begin
                hit     = 1'b1;
                hit_way = PTR_W'(w);
            end
        end
    end

endmodule

// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache between the fetch unit and
// the memory controller. One-cycle hits; on a miss a whole line is fetched,
// installed, and the requested word returned if the fetch still wants it.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rdy                       global enable; low freezes every register
//   flush                     one-cycle pulse, invalidates all lines
//   if_req, if_addr           fetch request and byte address
//   if_inst_valid, if_inst    registered instruction response
//   mc_req, mc_addr           line fill request (held until mc_line_valid)
//   mc_line_valid, mc_line    fill data, word k at bits [32k+31:32k]
//   dbg_state                 current FSM state
//
// Handshake: mc_req stays high from the cycle after a miss until the cycle
// after mc_line_valid is sampled with rdy high; mc_line_valid is a pulse that
// the memory controller must hold while rdy is low.
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int LINE_BYTES = ICS_LINE_BYTES,
    parameter int SETS       = ICS_SETS,
    parameter int WAYS       = ICS_WAYS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    flush,
    input  logic                    if_req,
    input  logic [31:0]             if_addr,
    output logic                    if_inst_valid,
    output logic [31:0]             if_inst,
    output logic                    mc_req,
    output logic [31:0]             mc_addr,
    input  logic                    mc_line_valid,
    input  logic [LINE_BYTES*8-1:0] mc_line,
    output ics_state_e              dbg_state
);

    localparam int LB_BITS  = $clog2(LINE_BYTES);
    localparam int IDX_BITS = $clog2(SETS);
    localparam int IDX_W    = ics_bits(SETS);
    localparam int TAG_W    = 32 - LB_BITS - IDX_BITS;
    localparam int WORDS    = LINE_BYTES / 4;
    localparam int WRD_W    = ics_bits(WORDS);
    localparam int PTR_W    = ics_bits(WAYS);
    localparam int LINE_W   = LINE_BYTES * 8;

    function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] a);
        logic [31:0] t;
        t = (a >> LB_BITS) & 32'(SETS - 1);
        return t[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        logic [31:0] t;
        t = a >> (LB_BITS + IDX_BITS);
        return t[TAG_W-1:0];
    endfunction

    function automatic logic [WRD_W-1:0] addr_word(input logic [31:0] a);
        logic [31:0] t;
        t = (a >> 2) & 32'(WORDS - 1);
        return t[WRD_W-1:0];
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a & ~32'(LINE_BYTES - 1);
    endfunction

    ics_state_e               state, state_nx;
    logic [31:0]              miss_addr;
    logic                     discard, discard_nx;
    logic [PTR_W-1:0]         rr_ptr [SETS];

    logic                     arr_hit;
    logic [PTR_W-1:0]         hit_way;
    logic [WAYS-1:0][LINE_W-1:0] rd_lines;
    logic [LINE_W-1:0]        hit_line;
    logic [WAYS-1:0]          wr_set_valid;
    logic [PTR_W-1:0]         vic_way;
    logic [IDX_W-1:0]         fill_index;

    logic                     hit_accept, take_miss, fill_install, fill_resp;
    logic [31:0]              hit_word, fill_word;

    assign fill_index = addr_index(miss_addr);

    icache_sa_array #(
        .LINE_BYTES (LINE_BYTES),
        .SETS       (SETS),
        .WAYS       (WAYS),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W),
        .PTR_W      (PTR_W),
        .LINE_W     (LINE_W)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush && rdy),
        .rd_index     (addr_index(if_addr)),
        .rd_tag       (addr_tag(if_addr)),
        .hit          (arr_hit),
        .hit_way      (hit_way),
        .rd_lines     (rd_lines),
        .wr_en        (fill_install && rdy),
        .wr_way       (vic_way),
        .wr_index     (fill_index),
        .wr_tag       (addr_tag(miss_addr)),
        .wr_line      (mc_line),
        .wr_set_valid (wr_set_valid)
    );

    // Victim: lowest invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        logic found;
        found   = 1'b0;
        vic_way = rr_ptr[fill_index];
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !wr_set_valid[w]) begin
                vic_way = PTR_W'(w);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        hit_line  = rd_lines[hit_way];
        hit_word  = hit_line[32*int'(addr_word(if_addr)) +: 32];
        fill_word = mc_line[32*int'(addr_word(if_addr)) +: 32];
    end

    always_comb begin
        state_nx     = state;
        discard_nx   = discard;
        hit_accept   = 1'b0;
        take_miss    = 1'b0;
        fill_install = 1'b0;
        fill_resp    = 1'b0;
        case (state)
            ICS_IDLE: begin
                discard_nx = 1'b0;
                // A flush cycle neither reports a hit nor starts a miss.
                if (if_req && !flush) begin
                    if (arr_hit) begin
                        hit_accept = 1'b1;
                    end else begin
                        take_miss = 1'b1;
                        state_nx  = ICS_MISS;
                    end
                end
            end
            ICS_MISS: begin
                if (flush) begin
                    discard_nx = 1'b1;
                end
                if (mc_line_valid) begin
                    state_nx   = ICS_IDLE;
                    discard_nx = 1'b0;
                    // A line requested before a flush is stale: drop it.
                    if (!discard && !flush) begin
                        fill_install = 1'b1;
                        fill_resp    = if_req && (line_base(if_addr) == miss_addr);
                    end
                end
            end
            default: state_nx = ICS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ICS_IDLE;
            discard       <= 1'b0;
            miss_addr     <= '0;
            if_inst_valid <= 1'b0;
            if_inst       <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else if (rdy) begin
            state         <= state_nx;
            discard       <= discard_nx;
            if_inst_valid <= hit_accept || fill_resp;
            if (hit_accept) begin
                if_inst <= hit_word;
            end else if (fill_resp) begin
                if_inst <= fill_word;
            end
            if (take_miss) begin
                miss_addr <= line_base(if_addr);
            end
            if (flush) begin
                for (int s = 0; s < SETS; s++) begin
                    rr_ptr[s] <= '0;
                end
            end else if (fill_install) begin
                rr_ptr[fill_index] <= (rr_ptr[fill_index] == PTR_W'(WAYS - 1))
                                      ? '0 : rr_ptr[fill_index] + 1'b1;
            end
        end
    end

    assign mc_req    = (state == ICS_MISS);
    assign mc_addr   = miss_addr;
    assign dbg_state = state;

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: self-checking bench for icache_sa at default geometry.
// Memory content for line address A: word k = (A >> 6) << 4 | k.
module tb_icache_sa;
    import icache_sa_pkg::*;

    localparam int LINE_W = ICS_LINE_BYTES * 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              flush;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_inst_valid;
    logic [31:0]       if_inst;
    logic              mc_req;
    logic [31:0]       mc_addr;
    logic              mc_line_valid;
    logic [LINE_W-1:0] mc_line;
    ics_state_e        dbg_state;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic        rdy_q = 1'b1;

    icache_sa dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .flush         (flush),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_inst_valid (if_inst_valid),
        .if_inst       (if_inst),
        .mc_req        (mc_req),
        .mc_addr       (mc_addr),
        .mc_line_valid (mc_line_valid),
        .mc_line       (mc_line),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] line_word(input logic [31:0] a);
        return ((a >> 6) << 4) | ((a >> 2) & 32'hf);
    endfunction

    function automatic logic [LINE_W-1:0] make_line(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int k = 0; k < ICS_LINE_BYTES / 4; k++) begin
            l[32*k +: 32] = ((base >> 6) << 4) | 32'(k);
        end
        return l;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    // A response is new only if the edge that produced it had rdy high;
    // while frozen the previous response is simply held.
    always @(posedge clk) rdy_q <= rdy;

    always @(negedge clk) begin
        if (if_inst_valid === 1'b1 && rdy_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("inst", if_inst, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic req_hit(input logic [31:0] a);
        if_req  = 1'b1;
        if_addr = a;
        exp_q.push_back(line_word(a));
        step();
        check("hit_valid", {31'd0, if_inst_valid}, 32'd1);
        check("hit_no_mcreq", {31'd0, mc_req}, 32'd0);
        if_req = 1'b0;
    endtask

    task automatic req_miss(input logic [31:0] a, input int lat);
        if_req  = 1'b1;
        if_addr = a;
        step();
        check("miss_mcreq", {31'd0, mc_req}, 32'd1);
        check("miss_mcaddr", mc_addr, a & 32'hffff_ffc0);
        check("miss_novalid", {31'd0, if_inst_valid}, 32'd0);
        repeat (lat) begin
            step();
            check("miss_hold", {31'd0, mc_req}, 32'd1);
        end
        mc_line_valid = 1'b1;
        mc_line       = make_line(a & 32'hffff_ffc0);
        exp_q.push_back(line_word(a));
        step();
        mc_line_valid = 1'b0;
        if_req        = 1'b0;
        check("fill_valid", {31'd0, if_inst_valid}, 32'd1);
        check("fill_mcreq_drop", {31'd0, mc_req}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; if_req = 1'b0;
        if_addr = '0; mc_line_valid = 1'b0; mc_line = '0;
        step();
        step();
        check("rst_valid", {31'd0, if_inst_valid}, 32'd0);
        check("rst_inst", if_inst, 32'd0);
        check("rst_mcreq", {31'd0, mc_req}, 32'd0);
        check("rst_mcaddr", mc_addr, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ICS_IDLE));
        rst = 1'b0;
        step();

        // Cold miss, then a hit in the same line.
        req_miss(32'h0000_0000, 3);
        req_hit(32'h0000_0004);

        // Three lines in set 0: third fill evicts way 0 (0x000).
        req_miss(32'h0000_0400, 2);
        req_miss(32'h0000_0800, 1);
        req_hit(32'h0000_0400);
        req_hit(32'h0000_0808);
        req_miss(32'h0000_0000, 2);
        req_hit(32'h0000_080c);

        // Flush invalidates; a request in the flush cycle gets nothing.
        if_req = 1'b1; if_addr = 32'h0000_0400; flush = 1'b1;
        step();
        flush = 1'b0; if_req = 1'b0;
        check("flush_nohit", {31'd0, if_inst_valid}, 32'd0);
        check("flush_nomiss", {31'd0, mc_req}, 32'd0);
        req_miss(32'h0000_0400, 1);

        // Flush during a miss: the fill is discarded.
        if_req = 1'b1; if_addr = 32'h0000_0440;
        step();
        check("fm_mcreq", {31'd0, mc_req}, 32'd1);
        if_req = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("fm_still_miss", {31'd0, mc_req}, 32'd1);
        mc_line_valid = 1'b1; mc_line = make_line(32'h0000_0440);
        step();
        mc_line_valid = 1'b0;
        check("fm_drop_valid", {31'd0, if_inst_valid}, 32'd0);
        check("fm_drop_mcreq", {31'd0, mc_req}, 32'd0);
        req_miss(32'h0000_0440, 1);

        // Redirect during a miss.
        rst = 1'b1;
        step();
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_1000;
        step();
        check("rd_mcaddr1", mc_addr, 32'h0000_1000);
        if_addr = 32'h0000_2004;
        step();
        step();
        mc_line_valid = 1'b1; mc_line = make_line(32'h0000_1000);
        step();
        mc_line_valid = 1'b0;
        check("rd_silent", {31'd0, if_inst_valid}, 32'd0);
        check("rd_mcreq_drop", {31'd0, mc_req}, 32'd0);
        step();
        check("rd_mcreq2", {31'd0, mc_req}, 32'd1);
        check("rd_mcaddr2", mc_addr, 32'h0000_2000);
        step();
        mc_line_valid = 1'b1; mc_line = make_line(32'h0000_2000);
        exp_q.push_back(32'h0000_0801);
        step();
        mc_line_valid = 1'b0; if_req = 1'b0;
        check("rd_fill_valid", {31'd0, if_inst_valid}, 32'd1);
        req_hit(32'h0000_1000);
        step();

        // rdy low around a hit.
        rdy = 1'b0; if_req = 1'b1; if_addr = 32'h0000_1004;
        repeat (3) begin
            step();
            check("rdy_hold_idle", {31'd0, if_inst_valid}, 32'd0);
        end
        rdy = 1'b1;
        exp_q.push_back(32'h0000_0401);
        step();
        check("rdy_resp", {31'd0, if_inst_valid}, 32'd1);
        rdy = 1'b0;
        repeat (3) begin
            step();
            check("rdy_hold_valid", {31'd0, if_inst_valid}, 32'd1);
            check("rdy_hold_inst", if_inst, 32'h0000_0401);
        end
        if_req = 1'b0; rdy = 1'b1;
        step();
        check("rdy_release", {31'd0, if_inst_valid}, 32'd0);

        // rdy low while the fill is presented.
        if_req = 1'b1; if_addr = 32'h0000_3000;
        step();
        check("rdyf_mcreq", {31'd0, mc_req}, 32'd1);
        rdy = 1'b0; mc_line_valid = 1'b1; mc_line = make_line(32'h0000_3000);
        repeat (3) begin
            step();
            check("rdyf_hold_req", {31'd0, mc_req}, 32'd1);
            check("rdyf_hold_v", {31'd0, if_inst_valid}, 32'd0);
        end
        rdy = 1'b1;
        exp_q.push_back(32'h0000_0c00);
        step();
        mc_line_valid = 1'b0; if_req = 1'b0;
        check("rdyf_valid", {31'd0, if_inst_valid}, 32'd1);
        check("rdyf_mcreq_drop", {31'd0, mc_req}, 32'd0);
        step();

        // Reset in the middle of a miss.
        if_req = 1'b1; if_addr = 32'h0000_5000;
        step();
        check("rm_mcreq", {31'd0, mc_req}, 32'd1);
        rst = 1'b1; if_req = 1'b0;
        step();
        rst = 1'b0;
        check("rm_mcreq_drop", {31'd0, mc_req}, 32'd0);
        check("rm_valid", {31'd0, if_inst_valid}, 32'd0);
        check("rm_state", 32'(dbg_state), 32'(ICS_IDLE));
        step();
        req_miss(32'h0000_2000, 1);
        req_miss(32'h0000_3004, 1);

        repeat (2) step();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache between the instruction fetch unit and the memory controller. It serves 32-bit instruction words on hit with one-cycle latency. On miss it requests one full line from the memory controller, installs it, then returns the requested word. Adds associativity, configurable geometry, a flush for `fence.i`, and safe handling of fetch redirects while a miss is outstanding.

## Interface
- `LINE_BYTES`, 64, bytes per line; power of two, ≥ 4.
- `SETS`, 16, number of sets; power of two.
- `WAYS`, 2, associativity; 1, 2 or 4.
- `clk  in  1` — clock.
- `rst  in  1` — reset, synchronous, active-high.
- `rdy  in  1` — global enable; when low, all state and outputs freeze.
- `flush  in  1` — one-cycle pulse; invalidates every line.
- `if_req  in  1` — fetch request valid.
- `if_addr  in  32` — fetch byte address; bits [1:0] ignored.
- `if_inst_valid  out  1` — `if_inst` valid this cycle.
- `if_inst  out  32` — instruction word.
- `mc_req  out  1` — line-fill request, held until `mc_line_valid`.
- `mc_addr  out  32` — line-aligned fill address.
- `mc_line_valid  in  1` — one-cycle pulse; `mc_line` valid.
- `mc_line  in  LINE_BYTES*8` — fill data; word k at bits [32k+31:32k].

## Operation
- Address split:
  - offset = `if_addr`[log2(LINE_BYTES)-1:2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
- Hit: `if_req` is high and some way of set[index] is valid with a matching tag. At most one way may match.
- FSM states:
  - IDLE: on hit, register the word. On miss, latch the line address and go to MISS.
  - MISS: `mc_req` = 1, `mc_addr` = latched address. On `mc_line_valid`, install the line, go to IDLE.
- Fill response: if `if_req` is still high and `if_addr` still maps to the latched line, the requested word is registered from `mc_line` in the fill cycle. Otherwise the line is installed silently.
- Victim selection: the lowest-index invalid way. If every way is valid, use the per-set round-robin pointer (log2(WAYS) bits), which increments on each fill into that set. Hits do not update the pointer.
- Flush:
  - Clears all valid bits; round-robin pointers are reset to 0.
  - If flush occurs in MISS, the pending line is discarded on arrival (not installed, no response) and the FSM returns to IDLE.
  - A hit is never reported in the flush cycle.
- Redirect: if `if_addr` changes during MISS, the fill still completes (the memory controller is never abandoned). The new address is looked up in the cycle after returning to IDLE.
- `rdy` = 0: no register changes, including on a simultaneous `mc_line_valid`. The memory controller must hold `mc_line_valid` until `rdy` is high.

## Timing
- Reset values: `if_inst_valid` = 0, `if_inst` = 0, `mc_req` = 0, `mc_addr` = 0; all valid bits 0; pointers 0; state IDLE.
- Hit: request in cycle N → `if_inst_valid` in cycle N+1, for one cycle per accepted request.
- Miss: detected in cycle N → `mc_req` high from N+1. `mc_line_valid` in cycle M → `if_inst_valid` in cycle M+1. `mc_req` drops in M+1.
- Back-to-back hits sustain one word per cycle.
- No lookups are accepted while in MISS.
- `rst` mid-miss: return to IDLE immediately and drop `mc_req`. The memory controller must discard the outstanding fill on `rst`.

## Structure
- `defines.v` gains: `ICS_LINE_BYTES`, `ICS_SETS`, `ICS_WAYS` defaults and state encodings `ICS_IDLE` / `ICS_MISS`.
- Sub-module `icache_sa_array`: per-way tag/valid/data storage, parallel tag compare, and hit-way output. `icache_sa` holds the FSM, victim selection and output registers.
- Target size: 200–300 lines of RTL.

## Test plan
All scenarios use default parameters; the filled line for address A has word k = A[31:6]<<4 | k.
- Cold miss at 0x0000_0000; line returned 3 cycles after `mc_req` → `mc_addr` = 0x0, `if_inst` = 0x0000_0000 one cycle after the fill. A following request to 0x4 hits with `if_inst` = 0x0000_0001, one cycle later, with no `mc_req`.
- 0x000, 0x400, 0x800 (all set 0) → the third fill evicts way 0. 0x400 hits; 0x000 misses again with `mc_addr` = 0x000.
- Fill 0x400, pulse `flush`, then request 0x400 → miss, `mc_req` reissued. Flush during MISS → line discarded; the next request to the same address misses.
- Request 0x1000 (miss), switch `if_addr` to 0x2004 before the fill → no `if_inst_valid` for the 0x1000 fill. Then `mc_addr` = 0x2000; once 0x2000 is filled, `if_inst` = 0x0000_0801. A later request to 0x1000 hits.
- `rdy` low for 3 cycles during a hit and during `mc_line_valid` → outputs frozen. The response arrives one cycle after `rdy` rises.
- `rst` asserted in MISS → next cycle `mc_req` = 0 and `if_inst_valid` = 0; every address misses.
